// File: rtl/ledmatrix_pkg.sv
// Shared types and default geometry for the LED matrix scan logic.
package ledmatrix_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LATCH    = 3'd3,
        DISPLAY  = 3'd4,
        GAP      = 3'd5
    } scan_state_e;

    localparam int DEFAULT_COLS   = 64;
    localparam int DEFAULT_ROWS   = 8;
    localparam int DEFAULT_PLANES = 4;
    localparam int DEFAULT_BASE   = 16;

endpackage

// File: rtl/bcm_ontime_timer.sv
// On-time counter for one BCM plane: counts DISPLAY cycles and decides the blank level of the next cycle.
// With BRIGHT_CTRL_EN the unblanked window shrinks to (BASE<<plane)*(bright+1)/16 cycles.
module bcm_ontime_timer
    import ledmatrix_pkg::*;
#(
    parameter int BASE   = DEFAULT_BASE,
    parameter int PLANES = DEFAULT_PLANES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       run,
    input  logic [1:0] plane,
`ifdef BRIGHT_CTRL_EN
    input  logic [3:0] bright,
`endif
    output logic       done,
    output logic       on_next
);
    // One spare bit so cnt_d can reach the full plane length without wrapping.
    localparam int CW = $clog2(BASE << (PLANES - 1)) + 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] len;

    assign len  = CW'(BASE) << plane;
    assign done = (cnt_q == len - CW'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef BRIGHT_CTRL_EN
    logic [3:0]    bright_q;
    logic [3:0]    bright_d;
    logic [CW+3:0] prod;

    // Brightness is captured on the LATCH edge, so the first DISPLAY cycle already uses the new value.
    assign bright_d = clear ? bright : bright_q;
    assign prod     = (CW+4)'(len) * (CW+4)'(bright_d) + (CW+4)'(len);
    assign on_next  = (cnt_d < prod[CW+3:4]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bright_q <= '0;
        end else if (clear) begin
            bright_q <= bright;
        end
    end
`else
    assign on_next = 1'b1;
`endif

endmodule

// File: rtl/bcm_scan_ctrl.sv
// BCM scan controller: shifts COLS pixels per plane, latches, then displays for BASE<<plane cycles.
// Optional BRIGHT_CTRL_EN adds the bright[3:0] input that trims the unblanked part of DISPLAY.
module bcm_scan_ctrl
    import ledmatrix_pkg::*;
#(
    parameter int COLS   = DEFAULT_COLS,
    parameter int ROWS   = DEFAULT_ROWS,
    parameter int PLANES = DEFAULT_PLANES,
    parameter int BASE   = DEFAULT_BASE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       pix_valid,
`ifdef BRIGHT_CTRL_EN
    input  logic [3:0] bright,
`endif
    output logic [2:0] row,
    output logic [7:0] col,
    output logic [1:0] plane,
    output logic       sclk,
    output logic       lat,
    output logic       blank,
    output logic [2:0] disp_row,
    output logic       frame_start,
    output logic [2:0] dbg_state
);
    scan_state_e state_q;
    logic [2:0]  row_q;
    logic [7:0]  col_q;
    logic [1:0]  plane_q;
    logic [2:0]  disp_row_q;
    logic        sclk_q;
    logic        lat_q;
    logic        blank_q;
    logic        frame_start_q;
    logic        tmr_done;
    logic        tmr_on_next;

    bcm_ontime_timer #(
        .BASE   (BASE),
        .PLANES (PLANES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == LATCH),
        .run     (state_q == DISPLAY),
        .plane   (plane_q),
`ifdef BRIGHT_CTRL_EN
        .bright  (bright),
`endif
        .done    (tmr_done),
        .on_next (tmr_on_next)
    );

    // Outputs are registered alongside the state, so each one reflects the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            row_q         <= '0;
            col_q         <= '0;
            plane_q       <= '0;
            disp_row_q    <= '0;
            sclk_q        <= 1'b0;
            lat_q         <= 1'b0;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            sclk_q        <= 1'b0;
            lat_q         <= 1'b0;
            frame_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    blank_q <= 1'b1;
                    if (enable) begin
                        state_q       <= SHIFT_LO;
                        row_q         <= '0;
                        col_q         <= '0;
                        plane_q       <= '0;
                        frame_start_q <= 1'b1;
                    end
                end
                SHIFT_LO: begin
                    if (pix_valid) begin
                        state_q <= SHIFT_HI;
                        sclk_q  <= 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (col_q == 8'(COLS - 1)) begin
                        state_q <= LATCH;
                        lat_q   <= 1'b1;
                        col_q   <= '0;
                    end else begin
                        state_q <= SHIFT_LO;
                        col_q   <= col_q + 8'd1;
                    end
                end
                LATCH: begin
                    state_q    <= DISPLAY;
                    disp_row_q <= row_q;
                    blank_q    <= !tmr_on_next;
                end
                DISPLAY: begin
                    if (tmr_done) begin
                        state_q <= GAP;
                        blank_q <= 1'b1;
                    end else begin
                        blank_q <= !tmr_on_next;
                    end
                end
                GAP: begin
                    if (plane_q == 2'(PLANES - 1)) begin
                        plane_q <= '0;
                        if (row_q == 3'(ROWS - 1)) begin
                            // Frame boundary: the only point where enable is honoured.
                            row_q <= '0;
                            if (enable) begin
                                state_q       <= SHIFT_LO;
                                frame_start_q <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            row_q   <= row_q + 3'd1;
                            state_q <= SHIFT_LO;
                        end
                    end else begin
                        plane_q <= plane_q + 2'd1;
                        state_q <= SHIFT_LO;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    blank_q <= 1'b1;
                end
            endcase
        end
    end

    assign row         = row_q;
    assign col         = col_q;
    assign plane       = plane_q;
    assign disp_row    = disp_row_q;
    assign sclk        = sclk_q;
    assign lat         = lat_q;
    assign blank       = blank_q;
    assign frame_start = frame_start_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_bcm_scan_ctrl.sv
// Directed bench for bcm_scan_ctrl: cycle-indexed vector table plus stall, enable-drop, reset and plane-timing sequences.
module tb_bcm_scan_ctrl;
    import ledmatrix_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       pix_valid = 1'b1;
    logic [2:0] row;
    logic [7:0] col;
    logic [1:0] plane;
    logic       sclk;
    logic       lat;
    logic       blank;
    logic [2:0] disp_row;
    logic       frame_start;
    logic [2:0] dbg_state;
`ifdef BRIGHT_CTRL_EN
    logic [3:0] bright = 4'd15;
    localparam int P3_ON = 64;
`else
    localparam int P3_ON = 128;
`endif

    bcm_scan_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pix_valid   (pix_valid),
`ifdef BRIGHT_CTRL_EN
        .bright      (bright),
`endif
        .row         (row),
        .col         (col),
        .plane       (plane),
        .sclk        (sclk),
        .lat         (lat),
        .blank       (blank),
        .disp_row    (disp_row),
        .frame_start (frame_start),
        .dbg_state   (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int sclk_cnt = 0;
    int fs_cnt   = 0;
    int on_cnt   = 0;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       fs;
        logic       sclk;
        logic       lat;
        logic       blank;
        logic [7:0] col;
        logic [1:0] plane;
        logic [2:0] row;
        logic [2:0] drow;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int c, logic [2:0] st, logic fs, logic sc, logic la, logic bl,
                                logic [7:0] co, logic [1:0] pl, logic [2:0] ro, logic [2:0] dr);
        vec_t v;
        v.cyc = c; v.st = st; v.fs = fs; v.sclk = sc; v.lat = la; v.blank = bl;
        v.col = co; v.plane = pl; v.row = ro; v.drow = dr;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock and sample #1 after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (sclk) sclk_cnt++;
        if (frame_start) fs_cnt++;
        if (!blank) on_cnt++;
    endtask

    task automatic step_to(int target);
        while (cyc < target) step();
    endtask

    function automatic logic [63:0] reset_vec();
        return 64'({dbg_state, row, col, plane, disp_row, sclk, lat, frame_start, blank});
    endfunction

    localparam logic [63:0] RESET_EXP = 64'({IDLE, 3'd0, 8'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1});

    // Hold reset two cycles, release on a falling edge; edge 1 after release is cycle 1.
    task automatic do_reset(string name);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check(name, reset_vec(), RESET_EXP);
        rst = 1'b1;
        cyc = 0; sclk_cnt = 0; fs_cnt = 0; on_cnt = 0;
    endtask

    task automatic wait_lat(string name, output int lat_cyc);
        int budget;
        budget = 0;
        while (!lat && budget < 2000) begin
            step();
            budget++;
        end
        lat_cyc = cyc;
        if (!lat) check(name, 64'(0), 64'(1));
    endtask

    // Called in the LATCH cycle; returns DISPLAY length and unblanked cycles.
    task automatic measure_display(output int dlen, output int don);
        int guard;
        dlen = 0; don = 0; guard = 0;
        step();
        while (dbg_state == DISPLAY && guard < 300) begin
            dlen++;
            if (!blank) don++;
            step();
            guard++;
        end
    endtask

    int lat_c [5];
    int dlen;
    int don;
    int viol;
    int exp_len [4] = '{16, 32, 64, 128};
    int exp_per [4] = '{146, 162, 194, 258};

    initial begin
        // Sequence A: table of cycle-indexed vectors across the first frame.
        tbl.push_back(mk(1,    SHIFT_LO, 1, 0, 0, 1, 0,  0, 0, 0));
        tbl.push_back(mk(2,    SHIFT_HI, 0, 1, 0, 1, 0,  0, 0, 0));
        tbl.push_back(mk(3,    SHIFT_LO, 0, 0, 0, 1, 1,  0, 0, 0));
        tbl.push_back(mk(128,  SHIFT_HI, 0, 1, 0, 1, 63, 0, 0, 0));
        tbl.push_back(mk(129,  LATCH,    0, 0, 1, 1, 0,  0, 0, 0));
        tbl.push_back(mk(130,  DISPLAY,  0, 0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(145,  DISPLAY,  0, 0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(146,  GAP,      0, 0, 0, 1, 0,  0, 0, 0));
        tbl.push_back(mk(147,  SHIFT_LO, 0, 0, 0, 1, 0,  1, 0, 0));
        tbl.push_back(mk(275,  LATCH,    0, 0, 1, 1, 0,  1, 0, 0));
        tbl.push_back(mk(307,  DISPLAY,  0, 0, 0, 0, 0,  1, 0, 0));
        tbl.push_back(mk(308,  GAP,      0, 0, 0, 1, 0,  1, 0, 0));
        tbl.push_back(mk(309,  SHIFT_LO, 0, 0, 0, 1, 0,  2, 0, 0));
        tbl.push_back(mk(503,  SHIFT_LO, 0, 0, 0, 1, 0,  3, 0, 0));
        tbl.push_back(mk(760,  GAP,      0, 0, 0, 1, 0,  3, 0, 0));
        tbl.push_back(mk(761,  SHIFT_LO, 0, 0, 0, 1, 0,  0, 1, 0));
        tbl.push_back(mk(6080, GAP,      0, 0, 0, 1, 0,  3, 7, 7));
        tbl.push_back(mk(6081, SHIFT_LO, 1, 0, 0, 1, 0,  0, 0, 7));

        enable = 1'b1;
        pix_valid = 1'b1;
        do_reset("reset_state");
        for (int i = 0; i < tbl.size(); i++) begin
            step_to(tbl[i].cyc);
            check($sformatf("vec_c%0d", tbl[i].cyc),
                  64'({dbg_state, frame_start, sclk, lat, blank, col, plane, row, disp_row}),
                  64'({tbl[i].st, tbl[i].fs, tbl[i].sclk, tbl[i].lat, tbl[i].blank,
                       tbl[i].col, tbl[i].plane, tbl[i].row, tbl[i].drow}));
        end
        check("frame_start_count", 64'(fs_cnt), 64'(2));
        check("sclk_per_frame", 64'(sclk_cnt), 64'(8 * 4 * 64));
        check("on_cycles_per_frame", 64'(on_cnt), 64'(8 * (16 + 32 + 64 + 128)));

        // Sequence B: plane periods and DISPLAY lengths, brightness on plane 3.
        do_reset("reset_b");
        for (int p = 0; p < 4; p++) begin
`ifdef BRIGHT_CTRL_EN
            bright = (p == 3) ? 4'd7 : 4'd15;
`endif
            wait_lat($sformatf("lat_timeout_p%0d", p), lat_c[p]);
            check($sformatf("lat_plane_p%0d", p), 64'(plane), 64'(p));
            measure_display(dlen, don);
            check($sformatf("display_len_p%0d", p), 64'(dlen), 64'(exp_len[p]));
            check($sformatf("display_on_p%0d", p), 64'(don),
                  64'((p == 3) ? P3_ON : exp_len[p]));
        end
`ifdef BRIGHT_CTRL_EN
        bright = 4'd15;
`endif
        wait_lat("lat_timeout_row1", lat_c[4]);
        step();
        check("disp_row_row1", 64'(disp_row), 64'(1));
        check("first_lat_cycle", 64'(lat_c[0]), 64'(129));
        for (int p = 0; p < 4; p++)
            check($sformatf("plane_period_p%0d", p), 64'(lat_c[p+1] - lat_c[p]), 64'(exp_per[p]));

        // Sequence C: 10-cycle stall at col 5, pix_valid ignored during DISPLAY.
        do_reset("reset_c");
        step_to(11);
        check("stall_entry", 64'({dbg_state, col}), 64'({SHIFT_LO, 8'd5}));
        pix_valid = 1'b0;
        viol = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (sclk || col != 8'd5 || dbg_state != SHIFT_LO) viol++;
        end
        check("stall_hold", 64'(viol), 64'(0));
        pix_valid = 1'b1;
        wait_lat("lat_timeout_stall", lat_c[0]);
        check("stall_lat_cycle", 64'(lat_c[0]), 64'(139));
        pix_valid = 1'b0;
        measure_display(dlen, don);
        check("stall_display_len", 64'(dlen), 64'(16));
        check("stall_gap_cycle", 64'({dbg_state, 32'(cyc)}), 64'({GAP, 32'd156}));
        pix_valid = 1'b1;
        step();
        check("stall_next_plane", 64'({dbg_state, plane, 32'(cyc)}), 64'({SHIFT_LO, 2'd1, 32'd157}));

        // Sequence D: enable dropped in row 3 finishes the frame then idles.
        do_reset("reset_d");
        step_to(3 * 760 + 1);
        check("drop_row3", 64'({row, plane}), 64'({3'd3, 2'd0}));
        enable = 1'b0;
        step_to(6080);
        check("drop_last_gap", 64'({dbg_state, row, plane}), 64'({GAP, 3'd7, 2'd3}));
        step();
        check("drop_idle", 64'({dbg_state, blank, frame_start}), 64'({IDLE, 1'b1, 1'b0}));
        fs_cnt = 0;
        viol = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (dbg_state != IDLE || !blank) viol++;
        end
        check("drop_stay_idle", 64'(viol), 64'(0));
        check("drop_no_frame_start", 64'(fs_cnt), 64'(0));

        // Sequence E: asynchronous reset during DISPLAY of row 4.
        enable = 1'b1;
        do_reset("reset_e");
        step_to(4 * 760 + 130);
        check("row4_display", 64'({dbg_state, disp_row, blank}), 64'({DISPLAY, 3'd4, 1'b0}));
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_values", reset_vec(), RESET_EXP);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        step();
        check("restart_after_reset", 64'({dbg_state, frame_start, row, plane, col}),
              64'({SHIFT_LO, 1'b1, 3'd0, 2'd0, 8'd0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcm_scan_ctrl.md
BCM_SCAN_CTRL -- requirements
Module: bcm_scan_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 64: columns shifted per row.
REQ-002 SHALL have parameter ROWS, default 8: scanned row pairs.
REQ-003 SHALL have parameter PLANES, default 4: BCM bitplanes per row.
REQ-004 SHALL have parameter BASE, default 16: plane-0 display cycles; multiple of 16.
REQ-005 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port enable  in  1  run scanning; sampled only at frame boundary.
REQ-008 SHALL have port pix_valid  in  1  pixel source has rgb for the current row/col/plane.
REQ-009 SHALL have ports row  out  3, col  out  8 and plane  out  2: pixel fetch address.
REQ-010 SHALL have ports sclk, lat and blank  out  1 each: panel shift clock, latch and blank.
REQ-011 SHALL have port disp_row  out  3  row address driven to the panel.
REQ-012 SHALL have port frame_start  out  1  one-cycle pulse at start of each frame.

Function
REQ-013 SHALL implement states IDLE, SHIFT_LO, SHIFT_HI, LATCH, DISPLAY and GAP.
REQ-014 IDLE: blank=1, sclk=0, lat=0; move to SHIFT_LO with row=0, plane=0 and col=0 when enable=1.
REQ-015 SHIFT_LO: sclk=0, blank=1; stay while pix_valid=0 (stall, outputs held); go to SHIFT_HI when pix_valid=1.
REQ-016 SHIFT_HI: sclk=1 for exactly one cycle; if col=COLS-1 go to LATCH, otherwise col+1 and go to SHIFT_LO.
REQ-017 LATCH: lat=1 and blank=1 for one cycle; disp_row loads row on this cycle's edge.
REQ-018 DISPLAY: lasts BASE<<plane cycles, counted by an on-time counter cleared on entry; blank=0 unless reduced per REQ-029.
REQ-019 GAP: blank=1 for one cycle; then plane+1, or plane=0 and row+1 when plane=PLANES-1.
REQ-020 GAP on the last plane of row ROWS-1: row wraps to 0; go to SHIFT_LO if enable=1, otherwise IDLE.
REQ-021 frame_start SHALL pulse on the first SHIFT_LO cycle with row=0 and plane=0, and only on that cycle, including the entry from IDLE.
REQ-022 Stalls SHALL never shorten or extend DISPLAY; pix_valid SHALL be ignored outside SHIFT_LO.
REQ-023 Deasserting enable mid-frame SHALL take effect only at the frame boundary per REQ-020.
REQ-024 The on-time counter SHALL be wide enough for BASE<<(PLANES-1) with no overflow; col SHALL wrap to 0 on every row.

Reset
REQ-025 rst=0 SHALL force IDLE immediately: row, col, plane and disp_row are 0; sclk=0, lat=0, frame_start=0 and blank=1.
REQ-026 Reset asserted mid-operation SHALL abandon the partial row; rst release SHALL cause no output glitch other than the REQ-025 values.

Configuration
REQ-027 Macro BRIGHT_CTRL_EN SHALL add input bright [3:0].
REQ-028 With BRIGHT_CTRL_EN undefined, the bright port SHALL be absent and blank=0 for the whole DISPLAY state.
REQ-029 With BRIGHT_CTRL_EN defined, blank=0 only while the on-time counter < ((BASE<<plane)*(bright+1))/16; bright is sampled on LATCH; DISPLAY length is unchanged.

Structure
REQ-030 A shared package ledmatrix_pkg SHALL hold the state enum type and the default constants COLS, ROWS, PLANES and BASE.
REQ-031 A single sub-module bcm_ontime_timer SHALL hold the on-time counter, its done flag and the brightness compare; the FSM SHALL be in bcm_scan_ctrl.

Verification (defaults; pix_valid=1 unless stated)
REQ-032 rst=0 then release with enable=1: frame_start is seen 1 cycle after release, then 64 sclk pulses, lat at cycle 129, and blank=0 for 16 cycles.
REQ-033 Run a full frame: per-row plane periods are 146/162/194/258 cycles, 760 per row, and frame_start pulses every 6080 cycles.
REQ-034 Hold pix_valid=0 for 10 cycles at col=5: sclk stays 0, col holds 5, the row period grows by 10, and DISPLAY stays 16 cycles.
REQ-035 Drop enable at row 3: scanning finishes row 7 plane 3, then stays in IDLE with blank=1 and no further frame_start.
REQ-036 BRIGHT_CTRL_EN defined with bright=7, plane 3: DISPLAY is 128 cycles with blank=0 for the first 64.
REQ-037 Assert rst during DISPLAY of row 4: all outputs reach the REQ-025 values at once, and after release row=0 and frame_start pulses.
